// File: rtl/hopfield_pkg.sv
// hopfield_pkg: shared constants and types for the sequential Hopfield network.
//   HOP_N     default neuron count (weight RAM holds HOP_N*HOP_N entries)
//   AW        weight RAM address width
//   COEF_W    weight width (signed, saturating to [-8,+7])
//   DATA_W    recall accumulator width (signed, saturating)
//   weight_t  signed weight type
//   acc_t     signed accumulator type
//   state_t   controller FSM states
package hopfield_pkg;

  localparam int HOP_N  = 25;
  localparam int AW     = 10;
  localparam int COEF_W = 4;
  localparam int DATA_W = 8;

  typedef logic signed [COEF_W-1:0] weight_t;
  typedef logic signed [DATA_W-1:0] acc_t;

  localparam weight_t W_MAX = weight_t'(7);
  localparam weight_t W_MIN = weight_t'(-8);

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    LEARN_RD,
    LEARN_WR,
    RECALL_ACC,
    RECALL_UPD,
    FINISH
  } state_t;

endpackage

// File: rtl/hopfield_if.sv
// hopfield_if: request/status handshake plus weight RAM bus of hopfield_seq.
//   clear_req, learn_req, learn_pat, recall_start, init_state : host -> core
//   busy, ack, done, converged, state_out, iter_count           : core -> host
//   w_addr, w_we, w_wdata                                        : core -> RAM
//   w_rdata (valid one cycle after w_addr)                       : RAM  -> core
// Modports: master = host/RAM side, slave = hopfield_seq.
interface hopfield_if
  import hopfield_pkg::*;
#(
  parameter int N = HOP_N
);

  logic          clear_req;
  logic          learn_req;
  logic [N-1:0]  learn_pat;
  logic          recall_start;
  logic [N-1:0]  init_state;
  logic          busy;
  logic          ack;
  logic          done;
  logic          converged;
  logic [N-1:0]  state_out;
  logic [3:0]    iter_count;
  logic [AW-1:0] w_addr;
  logic          w_we;
  weight_t       w_wdata;
  weight_t       w_rdata;

  modport master (
    output clear_req, learn_req, learn_pat, recall_start, init_state, w_rdata,
    input  busy, ack, done, converged, state_out, iter_count, w_addr, w_we, w_wdata
  );

  modport slave (
    input  clear_req, learn_req, learn_pat, recall_start, init_state, w_rdata,
    output busy, ack, done, converged, state_out, iter_count, w_addr, w_we, w_wdata
  );

endinterface

// File: rtl/hopfield_mac.sv
// hopfield_mac: sign-select saturating accumulator used during recall.
//   clk  rising-edge clock
//   clr  synchronous clear of the accumulator (wins over en)
//   en   fold w into the running sum this cycle
//   add  1 = add w, 0 = subtract w
//   w    signed weight from the RAM
//   sum  combinational running sum including this cycle's term (saturated)
module hopfield_mac
  import hopfield_pkg::*;
(
  input  logic    clk,
  input  logic    clr,
  input  logic    en,
  input  logic    add,
  input  weight_t w,
  output acc_t    sum
);

  acc_t acc_p0;

  // One guard bit is enough for an 8-bit + 4-bit sum; clamp on overflow.
  function automatic acc_t sat_acc(acc_t a, weight_t b, logic pos);
    logic signed [DATA_W:0] ea;
    logic signed [DATA_W:0] eb;
    logic signed [DATA_W:0] t;
    ea = a;
    eb = b;
    t  = pos ? (ea + eb) : (ea - eb);
    if (t[DATA_W] != t[DATA_W-1])
      return t[DATA_W] ? {1'b1, {(DATA_W-1){1'b0}}} : {1'b0, {(DATA_W-1){1'b1}}};
    return t[DATA_W-1:0];
  endfunction

  assign sum = en ? sat_acc(acc_p0, w, add) : acc_p0;

  // stage p0: running sum register
  always_ff @(posedge clk) begin
    if (clr) acc_p0 <= '0;
    else     acc_p0 <= sum;
  end

endmodule

// File: rtl/hopfield_seq.sv
// hopfield_seq: sequential Hopfield network with external weight RAM.
// Clears, learns (Hebbian +/-1 per pattern, saturating) and recalls with
// synchronous updates until a fixed point or MAX_ITER iterations.
//   clk   rising-edge clock
//   rst   synchronous, active-low reset
//   bus   hopfield_if.slave: requests, status, result vector, RAM port
// Parameters: N (neuron count, N*N <= 1024), MAX_ITER (recall limit).
// Build option: HOPFIELD_ZERO_DIAG_EN keeps diagonal weights at 0 during LEARN.
module hopfield_seq
  import hopfield_pkg::*;
#(
  parameter int N        = HOP_N,
  parameter int MAX_ITER = 15
) (
  input  logic clk,
  input  logic rst,
  hopfield_if.slave bus
);

  localparam int            CW   = $clog2(N + 1);
  localparam logic [AW-1:0] LAST = AW'(N * N - 1);

  state_t        state;
  state_t        state_nxt;
  logic [AW-1:0] addr;
  logic [AW-1:0] addr_inc;
  logic [CW-1:0] row;
  logic [CW-1:0] col;
  logic [N-1:0]  pat;
  logic [N-1:0]  cur;
  logic [N-1:0]  nxt_vec;
  logic [3:0]    iter;
  logic          conv;
  logic          ack_r;
  logic          vld_p1;
  logic          sel_p1;
  logic          take_learn;
  logic          take_recall;
  logic          drain;
  logic          same;
  logic          iter_end;
  logic          we;
  weight_t       wdata;
  acc_t          sum;

  function automatic weight_t sat_step(weight_t w, logic up);
    if (up) return (w == W_MAX) ? w : w + weight_t'(1);
    return (w == W_MIN) ? w : w - weight_t'(1);
  endfunction

  // Lower-priority requests seen together with a higher one are dropped.
  assign take_learn  = (state == IDLE) && !bus.clear_req && bus.learn_req;
  assign take_recall = (state == IDLE) && !bus.clear_req && !bus.learn_req && bus.recall_start;

  // Address walks 0..N*N-1 in row-major order for every mode and wraps so
  // nothing above the last entry is ever driven.
  assign addr_inc = (addr == LAST) ? '0 : addr + AW'(1);
  assign drain    = (state == RECALL_ACC) && (col == CW'(N));
  assign same     = (nxt_vec == cur);
  assign iter_end = ((iter + 4'd1) == 4'(MAX_ITER));

  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    we        = 1'b0;
    wdata     = '0;
    case (state)
      IDLE: begin
        if (bus.clear_req)         state_nxt = CLEAR;
        else if (bus.learn_req)    state_nxt = LEARN_RD;
        else if (bus.recall_start) state_nxt = RECALL_ACC;
      end
      CLEAR: begin
        we = 1'b1;
        if (addr == LAST) state_nxt = IDLE;
      end
      LEARN_RD: state_nxt = LEARN_WR;
      LEARN_WR: begin
        wdata = sat_step(bus.w_rdata, pat[row] == pat[col]);
`ifdef HOPFIELD_ZERO_DIAG_EN
        we = (row != col);
`else
        we = 1'b1;
`endif
        state_nxt = (addr == LAST) ? IDLE : LEARN_RD;
      end
      RECALL_ACC: begin
        if (drain && (row == CW'(N - 1))) state_nxt = RECALL_UPD;
      end
      RECALL_UPD: state_nxt = (same || iter_end) ? FINISH : RECALL_ACC;
      FINISH:     state_nxt = IDLE;
      default:    state_nxt = IDLE;
    endcase
  end

  // stage p0 -> p1: read issue; the state bit for the issued column travels
  // with the read so it meets w_rdata one cycle later.
  always_ff @(posedge clk) begin
    if (!rst) begin
      addr   <= '0;
      row    <= '0;
      col    <= '0;
      cur    <= '0;
      iter   <= '0;
      conv   <= 1'b0;
      ack_r  <= 1'b0;
      vld_p1 <= 1'b0;
    end else begin
      ack_r  <= 1'b0;
      vld_p1 <= 1'b0;
      case (state)
        IDLE: begin
          addr <= '0;
          row  <= '0;
          col  <= '0;
          if (take_recall) begin
            cur  <= bus.init_state;
            iter <= '0;
            conv <= 1'b0;
          end
        end
        CLEAR: begin
          addr <= addr_inc;
          if (addr == LAST) ack_r <= 1'b1;
        end
        LEARN_WR: begin
          addr <= addr_inc;
          if (col == CW'(N - 1)) begin
            col <= '0;
            row <= row + CW'(1);
          end else begin
            col <= col + CW'(1);
          end
          if (addr == LAST) ack_r <= 1'b1;
        end
        RECALL_ACC: begin
          if (drain) begin
            col <= '0;
            row <= (row == CW'(N - 1)) ? '0 : row + CW'(1);
          end else begin
            col    <= col + CW'(1);
            addr   <= addr_inc;
            vld_p1 <= 1'b1;
          end
        end
        RECALL_UPD: begin
          addr <= '0;
          row  <= '0;
          col  <= '0;
          if (same) begin
            conv <= 1'b1;
          end else begin
            cur  <= nxt_vec;
            iter <= iter + 4'd1;
          end
        end
        default: ;
      endcase
    end
  end

  // stage p1 -> p2: drain cycle folds the last term and latches next[k].
  always_ff @(posedge clk) begin
    if (take_learn) pat <= bus.learn_pat;
    if ((state == RECALL_ACC) && !drain) sel_p1 <= cur[col];
    if (drain) nxt_vec[row] <= (sum > acc_t'(0));
  end

  hopfield_mac u_mac (
    .clk (clk),
    .clr (take_recall || drain),
    .en  (vld_p1),
    .add (sel_p1),
    .w   (bus.w_rdata),
    .sum (sum)
  );

  assign bus.busy       = (state != IDLE);
  assign bus.ack        = ack_r;
  assign bus.done       = (state == FINISH);
  assign bus.converged  = conv;
  assign bus.state_out  = cur;
  assign bus.iter_count = iter;
  assign bus.w_addr     = addr;
  assign bus.w_we       = we;
  assign bus.w_wdata    = wdata;

endmodule

// File: tb/tb_hopfield_seq.sv
// tb_hopfield_seq: scoreboard bench for hopfield_seq with a behavioural
// Hebbian/recall model and a one-cycle-latency RAM model.
`timescale 1ns/1ps
module tb_hopfield_seq;
  import hopfield_pkg::*;

  localparam int N        = 25;
  localparam int NN       = N * N;
  localparam int MAX_ITER = 15;
  localparam logic [N-1:0] PD  = 25'h0E94A4F;
  localparam logic [N-1:0] PC  = 25'h074A11F;
  localparam logic [N-1:0] PJ  = 25'h1E0843E;
  localparam logic [N-1:0] PM  = 25'h118D771;
  localparam logic [N-1:0] P37 = 25'h1F00001;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  hopfield_if #(.N(N)) bus();
  hopfield_seq #(.N(N), .MAX_ITER(MAX_ITER)) dut (.clk(clk), .rst(rst), .bus(bus));

  logic signed [3:0] mem [0:1023];
  always @(posedge clk) begin
    if (bus.w_we) mem[bus.w_addr] <= bus.w_wdata;
    bus.w_rdata <= mem[bus.w_addr];
  end

  typedef struct {
    bit           is_done;
    bit           care;
    bit           conv;
    logic [N-1:0] st;
    int           iter;
    int           acc_cyc;
    int           lat;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   we_cnt = 0;
  int   max_addr = 0;
  int   wm [NN];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic int clampi(int v, int lo, int hi);
    return (v < lo) ? lo : ((v > hi) ? hi : v);
  endfunction

  task automatic model_clear();
    for (int i = 0; i < NN; i++) wm[i] = 0;
  endtask

  task automatic model_learn(input logic [N-1:0] p);
    for (int k = 0; k < N; k++)
      for (int m = 0; m < N; m++) begin
`ifdef HOPFIELD_ZERO_DIAG_EN
        if (k == m) continue;
`endif
        wm[k*N+m] = clampi(wm[k*N+m] + ((p[k] == p[m]) ? 1 : -1), -8, 7);
      end
  endtask

  task automatic model_recall(input logic [N-1:0] init, output logic [N-1:0] fin,
                              output bit conv, output int it);
    logic [N-1:0] s;
    logic [N-1:0] nx;
    int           sum;
    bit           stop;
    s = init; it = 0; conv = 0; stop = 0;
    while (!stop) begin
      for (int k = 0; k < N; k++) begin
        sum = 0;
        for (int m = 0; m < N; m++)
          sum = clampi(sum + (s[m] ? wm[k*N+m] : -wm[k*N+m]), -128, 127);
        nx[k] = (sum > 0);
      end
      if (nx == s) begin
        conv = 1; stop = 1;
      end else begin
        s = nx; it++;
        if (it == MAX_ITER) begin conv = 0; stop = 1; end
      end
    end
    fin = s;
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (rst) begin
      if (bus.w_we) we_cnt++;
      if (int'(bus.w_addr) > max_addr) max_addr = int'(bus.w_addr);
      if (bus.ack || bus.done) begin
        if (sb.size() == 0) begin
          chk("unexpected_out", {62'd0, bus.done, bus.ack}, 64'd0);
        end else begin
          e = sb.pop_front();
          chk("out_kind", {62'd0, bus.done, bus.ack}, e.is_done ? 64'd2 : 64'd1);
          if (e.is_done && e.care) begin
            chk("converged", bus.converged, e.conv);
            chk("state_out", bus.state_out, e.st);
            chk("iter_count", bus.iter_count, e.iter);
            if (e.lat >= 0) chk("done_latency", cyc - e.acc_cyc, e.lat);
          end
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic push_ack();
    exp_t x;
    x = '{is_done: 1'b0, care: 1'b0, conv: 1'b0, st: '0, iter: 0, acc_cyc: 0, lat: -1};
    sb.push_back(x);
  endtask

  task automatic wait_idle(input string nm);
    int n;
    n = 0;
    while ((bus.busy || sb.size() != 0) && n < 20000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20000) begin
      total++; bad++;
      $display("FAIL %s_timeout: still busy after %0d cycles", nm, n);
      sb.delete();
    end
  endtask

  task automatic do_clear();
    @(negedge clk);
    bus.clear_req = 1'b1;
    push_ack();
    model_clear();
    @(negedge clk);
    bus.clear_req = 1'b0;
    wait_idle("clear");
  endtask

  task automatic do_learn(input logic [N-1:0] p);
    @(negedge clk);
    bus.learn_req = 1'b1;
    bus.learn_pat = p;
    push_ack();
    model_learn(p);
    @(negedge clk);
    bus.learn_req = 1'b0;
    wait_idle("learn");
  endtask

  task automatic do_recall(input logic [N-1:0] init, input int lat, input bit poke);
    exp_t x;
    logic [N-1:0] fin;
    bit c;
    int it;
    model_recall(init, fin, c, it);
    @(negedge clk);
    bus.recall_start = 1'b1;
    bus.init_state = init;
    x = '{is_done: 1'b1, care: 1'b1, conv: c, st: fin, iter: it, acc_cyc: cyc + 1, lat: lat};
    sb.push_back(x);
    @(negedge clk);
    bus.recall_start = 1'b0;
    if (poke) begin
      repeat (30) @(negedge clk);
      bus.clear_req = 1'b1;
      bus.learn_req = 1'b1;
      @(negedge clk);
      bus.clear_req = 1'b0;
      bus.learn_req = 1'b0;
    end
    wait_idle("recall");
    repeat (3) @(negedge clk);
    chk("converged_held", bus.converged, c);
    chk("state_held", bus.state_out, fin);
  endtask

  task automatic ram_vs_model(input string nm);
    int mism;
    mism = 0;
    for (int i = 0; i < NN; i++)
      if (mem[i] !== 4'(wm[i])) mism++;
    chk(nm, mism, 0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [N-1:0] p;
    logic [N-1:0] q;
    bus.clear_req = 1'b0;
    bus.learn_req = 1'b0;
    bus.recall_start = 1'b0;
    bus.learn_pat = '0;
    bus.init_state = '0;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_busy", bus.busy, 0);
    chk("rst_ack", bus.ack, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_converged", bus.converged, 0);
    chk("rst_state_out", bus.state_out, 0);
    chk("rst_iter", bus.iter_count, 0);
    chk("rst_w_addr", bus.w_addr, 0);
    chk("rst_w_we", bus.w_we, 0);
    chk("rst_w_wdata", bus.w_wdata, 0);
    rst = 1'b1;

    // Coinciding requests: only CLEAR runs.
    @(negedge clk);
    we_cnt = 0;
    bus.clear_req = 1'b1;
    bus.learn_req = 1'b1;
    bus.recall_start = 1'b1;
    bus.learn_pat = P37;
    push_ack();
    model_clear();
    @(negedge clk);
    bus.clear_req = 1'b0;
    bus.learn_req = 1'b0;
    bus.recall_start = 1'b0;
    wait_idle("clear_prio");
    chk("clear_we_cycles", we_cnt, NN);
    repeat (5) @(negedge clk);
    chk("nothing_after_clear", bus.busy, 0);
    ram_vs_model("clear_readback");

    // Recall on all-zero weights from 0: immediate fixed point, fixed latency.
    do_recall('0, 651, 1'b0);

    // Learn P37 twice.
    we_cnt = 0;
    do_learn(P37);
`ifdef HOPFIELD_ZERO_DIAG_EN
    chk("learn_we_cycles", we_cnt, NN - N);
`else
    chk("learn_we_cycles", we_cnt, NN);
`endif
    do_learn(P37);
    chk("w_0_24", int'(mem[24]), 2);
    chk("w_0_5", int'(mem[5]), -2);
    ram_vs_model("learn2_ram");

    // Saturation: keep learning the same pattern.
    for (int i = 0; i < 7; i++) do_learn(P37);
    chk("w_sat_pos", int'(mem[24]), 7);
    chk("w_sat_neg", int'(mem[5]), -8);
    ram_vs_model("sat_ram");

    // Letter patterns and recall from a corrupted D, with ignored requests.
    do_clear();
    do_learn(PD);
    do_learn(PC);
    do_learn(PJ);
    do_learn(PM);
    ram_vs_model("letters_ram");
    do_recall(PD ^ 25'h0000008, -1, 1'b1);
    chk("recall_D_state", bus.state_out, PD);
    chk("recall_D_conv", bus.converged, 1);
    ram_vs_model("ignored_req_ram");

    // Randomized recalls near stored patterns.
    for (int i = 0; i < 3; i++) begin
      case ($urandom_range(0, 3))
        0: p = PD;
        1: p = PC;
        2: p = PJ;
        default: p = PM;
      endcase
      p = p ^ (25'd1 << $urandom_range(0, N - 1)) ^ (25'd1 << $urandom_range(0, N - 1));
      do_recall(p, -1, 1'b0);
    end

    // Fresh random memory.
    do_clear();
    p = N'($urandom());
    q = N'($urandom());
    do_learn(p);
    do_learn(q);
    ram_vs_model("rand_ram");
    do_recall(N'($urandom()), -1, 1'b0);

    // Reset halfway through LEARN: aborts silently, recall still accepted.
    @(negedge clk);
    bus.learn_req = 1'b1;
    bus.learn_pat = N'($urandom());
    @(negedge clk);
    bus.learn_req = 1'b0;
    repeat (624) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("abort_busy", bus.busy, 0);
    chk("abort_ack", bus.ack, 0);
    rst = 1'b1;
    repeat (5) @(negedge clk);
    @(negedge clk);
    bus.recall_start = 1'b1;
    bus.init_state = N'($urandom());
    begin
      exp_t x;
      x = '{is_done: 1'b1, care: 1'b0, conv: 1'b0, st: '0, iter: 0, acc_cyc: 0, lat: -1};
      sb.push_back(x);
    end
    @(negedge clk);
    bus.recall_start = 1'b0;
    chk("post_abort_recall_busy", bus.busy, 1);
    wait_idle("post_abort");

    chk("addr_in_range", max_addr < NN, 1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/hopfield_seq.md
HOPFIELD_SEQ -- requirements
Module: hopfield_seq

Interface
REQ-001 Parameter N, default 25: neuron count; weight array is N*N entries.
REQ-002 Parameter MAX_ITER, default 15: recall iteration limit.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst  input  1  reset, synchronous, active-low.
REQ-005 clear_req  input  1  request to zero all weights; sampled in IDLE only.
REQ-006 learn_req  input  1  request to add learn_pat to weights; sampled in IDLE only.
REQ-007 learn_pat  input  N  pattern to learn; captured when the request is accepted.
REQ-008 recall_start  input  1  request to start recall from init_state; sampled in IDLE only.
REQ-009 init_state  input  N  initial neuron vector; captured when recall is accepted.
REQ-010 busy  output  1  high in every state except IDLE.
REQ-011 ack  output  1  one-cycle pulse when a clear or learn completes.
REQ-012 done  output  1  one-cycle pulse when recall finishes.
REQ-013 converged  output  1  at done: 1 = fixed point reached, 0 = MAX_ITER hit; held until next recall is accepted.
REQ-014 state_out  output  N  current neuron vector; holds the final result after done.
REQ-015 iter_count  output  4  completed recall iterations.
REQ-016 w_addr  output  10  weight RAM address, k*N+m.
REQ-017 w_we  output  1  weight RAM write enable.
REQ-018 w_wdata  output  4  signed weight write data.
REQ-019 w_rdata  input  4  signed weight read data; valid one cycle after w_addr.

Function
REQ-020 FSM states: IDLE, CLEAR, LEARN_RD, LEARN_WR, RECALL_ACC, RECALL_UPD, FINISH.
REQ-021 IDLE priority when requests coincide: clear_req > learn_req > recall_start; lower-priority requests are dropped, not queued.
REQ-022 Requests arriving while busy are ignored.
REQ-023 CLEAR: writes 0 to addresses 0..N*N-1, one per cycle (625 cycles); ack, then IDLE.
REQ-024 LEARN: per (k,m), read cycle then write cycle: w += (pat[k]==pat[m]) ? +1 : -1, saturated to [-8,+7]; 1250 cycles total; ack, then IDLE.
REQ-025 RECALL_ACC, per neuron k: issue reads m=0..N-1; 8-bit signed accumulator adds w when state[m]=1, subtracts it otherwise; one drain cycle for read latency (26 cycles per neuron).
REQ-026 Synchronous update: next[k] = (sum > 0); all sums use the state vector from the start of the iteration.
REQ-027 RECALL_UPD (1 cycle): if next==state, converged<=1 and go to FINISH; else state<=next, iter_count+1, and go to FINISH with converged<=0 if iter_count reaches MAX_ITER, otherwise back to RECALL_ACC.
REQ-028 FINISH: done pulse for 1 cycle, then IDLE.
REQ-029 w_we is asserted only in CLEAR and LEARN_WR; no address above N*N-1 is driven.

Reset
REQ-030 When rst=0 at a clock edge: state IDLE; busy, ack, done, converged, w_we = 0; state_out, iter_count, w_addr, w_wdata = 0.
REQ-031 Reset mid-operation aborts immediately with no ack or done; RAM contents are left as-is (partial learn is possible).

Configuration
REQ-032 Macro HOPFIELD_ZERO_DIAG_EN defined: LEARN skips writes where k==m, so diagonal weights stay at their CLEAR value 0.
REQ-033 Macro undefined: diagonal weights accumulate +1 per learned pattern like every other entry.

Structure
REQ-034 Package hopfield_pkg holds N, the address width, the signed weight typedef, the accumulator typedef, and the FSM state enum.
REQ-035 Sub-module hopfield_mac: sign-select accumulator with clear and saturation, used by RECALL_ACC.

Verification
REQ-036 Clear, then read back all 625 addresses through the RAM model -> every weight 0; exactly one ack pulse.
REQ-037 Clear, then learn pattern 25'h1F00001 twice -> w[0*25+24] = +2 and w[0*25+5] = -2.
REQ-038 Learn D, C, J, M (D=25'h0E94A4F, C=25'h074A11F, J=25'h1E0843E, M=25'h118D771), then recall from D with bit 3 flipped -> done with converged=1 and state_out=D.
REQ-039 After clearing only, recall from 25'h0000000 -> all sums are 0, so next=0 equals state; converged=1, iter_count=0, done at cycle 651 after acceptance.
REQ-040 Assert clear_req, learn_req and recall_start in the same IDLE cycle -> only CLEAR runs (625 w_we cycles), then ack; nothing else starts.
REQ-041 Assert rst=0 halfway through LEARN -> next cycle busy=0 and no ack; a following recall_start is accepted normally.
